// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES-128 constants, FSM state type, S-box and xtime helpers
package aes_pkg;

    localparam logic [3:0] AES_NR = 4'd10;

    typedef enum logic [1:0] {IDLE, RUN, DONE} aes_state_e;

    // Byte b of the forward S-box sits at bits [2047-8*b -: 8].
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TABLE[{~b, 3'b111} -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_encrypt_iter_if.sv
// rtl/aes_encrypt_iter_if.sv - plaintext/ciphertext valid-ready handshake bundle
interface aes_encrypt_iter_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] plaintext;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] ciphertext;

    modport master (
        output in_valid, plaintext, out_ready,
        input  in_ready, out_valid, ciphertext
    );

    modport slave (
        input  in_valid, plaintext, out_ready,
        output in_ready, out_valid, ciphertext
    );
endinterface

// File: rtl/aes_round.sv
// rtl/aes_round.sv - one combinational AES round: SubBytes, ShiftRows, MixColumns, AddRoundKey
module aes_round
    import aes_pkg::*;
(
    input  logic [127:0] state_in,
    input  logic [127:0] rkey,
    input  logic         last,
    output logic [127:0] state_out
);
    // Byte index i = 4*col + row, byte 0 in the top bits.
    logic [7:0] sb [16];
    logic [7:0] sr [16];
    logic [7:0] mc [16];

    for (genvar i = 0; i < 16; i++) begin : g_sub
        assign sb[i] = sbox(state_in[127-8*i -: 8]);
    end

    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            assign sr[4*c+r] = sb[4*((c+r)%4)+r];
        end

        assign mc[4*c+0] = xtime(sr[4*c+0]) ^ xtime(sr[4*c+1]) ^ sr[4*c+1] ^ sr[4*c+2] ^ sr[4*c+3];
        assign mc[4*c+1] = sr[4*c+0] ^ xtime(sr[4*c+1]) ^ xtime(sr[4*c+2]) ^ sr[4*c+2] ^ sr[4*c+3];
        assign mc[4*c+2] = sr[4*c+0] ^ sr[4*c+1] ^ xtime(sr[4*c+2]) ^ xtime(sr[4*c+3]) ^ sr[4*c+3];
        assign mc[4*c+3] = xtime(sr[4*c+0]) ^ sr[4*c+0] ^ sr[4*c+1] ^ sr[4*c+2] ^ xtime(sr[4*c+3]);
    end

    for (genvar i = 0; i < 16; i++) begin : g_ark
        assign state_out[127-8*i -: 8] = (last ? sr[i] : mc[i]) ^ rkey[127-8*i -: 8];
    end
endmodule

// File: rtl/aes_encrypt_iter.sv
// rtl/aes_encrypt_iter.sv - iterative AES-128 encryptor, one cipher round per clock
module aes_encrypt_iter
    import aes_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    aes_encrypt_iter_if.slave   bus,
    input  logic [127:0]        round_key0,
    input  logic [127:0]        round_key1,
    input  logic [127:0]        round_key2,
    input  logic [127:0]        round_key3,
    input  logic [127:0]        round_key4,
    input  logic [127:0]        round_key5,
    input  logic [127:0]        round_key6,
    input  logic [127:0]        round_key7,
    input  logic [127:0]        round_key8,
    input  logic [127:0]        round_key9,
    input  logic [127:0]        round_key10
);
    aes_state_e   fsm;
    logic [3:0]   rnd;
    logic [127:0] state;
    logic [127:0] rkey;
    logic [127:0] round_out;
    logic         last_round;
    logic         in_ready_q;
    logic         out_valid_q;

    // Keys are not latched: the upstream key source holds them for the whole block.
    always_comb begin
        rkey = round_key1;
        case (rnd)
            4'd2:    rkey = round_key2;
            4'd3:    rkey = round_key3;
            4'd4:    rkey = round_key4;
            4'd5:    rkey = round_key5;
            4'd6:    rkey = round_key6;
            4'd7:    rkey = round_key7;
            4'd8:    rkey = round_key8;
            4'd9:    rkey = round_key9;
            4'd10:   rkey = round_key10;
            default: rkey = round_key1;
        endcase
    end

    assign last_round = (rnd == AES_NR);

    aes_round u_round (
        .state_in  (state),
        .rkey      (rkey),
        .last      (last_round),
        .state_out (round_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm         <= IDLE;
            rnd         <= 4'd0;
            state       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (fsm)
                IDLE: begin
                    if (bus.in_valid) begin
                        state      <= bus.plaintext ^ round_key0;
                        rnd        <= 4'd1;
                        fsm        <= RUN;
                        in_ready_q <= 1'b0;
                    end
                end
                RUN: begin
                    state <= round_out;
                    if (last_round) begin
                        fsm         <= DONE;
                        out_valid_q <= 1'b1;
                    end else begin
                        rnd <= rnd + 4'd1;
                    end
                end
                DONE: begin
                    // No accept on the output handshake cycle; IDLE is always visited first.
                    if (bus.out_ready) begin
                        fsm         <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    fsm         <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.ciphertext = state;
endmodule
